spi_cmd_receiver: RTL and testbench
===================================

Name: spi_cmd_receiver

Overview:
Upstream front end for the system controller. Receives 32-bit command words from the external SPI master (mode 0, MSB first) and synchronizes the pins into the `clock` domain. Buffers complete words in a small FIFO and presents each one as `cmd_data` with a single-cycle `latch_data` strobe. The same strobe pairing is what the system controller consumes. Returns a status byte on `miso` during each word.

Parameters:
DATA_WIDTH, 32, command word width in bits
FIFO_DEPTH, 4, number of buffered words (power of two)
FIFO_ADDR_WIDTH, 2, log2(FIFO_DEPTH)

Ports:
clock  input  1  system clock; all logic on its rising edge
reset_n  input  1  synchronous active-low reset
sclk  input  1  SPI clock pin, asynchronous to `clock`
mosi  input  1  SPI data in, asynchronous
ss_n  input  1  SPI select, active low, asynchronous
miso  output  1  SPI data out
hold_n  input  1  high = consumer may accept a new word
clear_errors  input  1  clears the sticky error flags
cmd_data  output  DATA_WIDTH  last delivered command word
latch_data  output  1  one-cycle strobe; `cmd_data` is valid while it is high
fifo_count  output  FIFO_ADDR_WIDTH+1  words currently buffered
overflow  output  1  sticky: a complete word was dropped because the FIFO was full
frame_error  output  1  sticky: `ss_n` rose with a partial word pending

Behaviour:
Reset (`reset_n`=0 at a clock edge) clears or sets the following:
- `cmd_data`=0, `latch_data`=0, `fifo_count`=0, `overflow`=0, `frame_error`=0, `miso`=0.
- FIFO pointers and bit counter = 0; state = WAIT_IDLE.
- Synchronizer flops: `sclk`=0, `mosi`=0, `ss_n`=1.
- Reset asserted mid-frame discards the partial word and any buffered words.

Synchronization and edge detection:
- 2-flop synchronizer on each pin; a third `sclk` flop is used for edge detection.
- Pin edge to internal `sclk` rise/fall detect = 3 clocks.
- `sclk` must stay high ≥4 clocks and low ≥4 clocks; faster SPI clocks are out of spec.

State machine:
- WAIT_IDLE: ignore all traffic. Go to IDLE when synced `ss_n`=1. This prevents mid-frame misalignment after reset.
- IDLE: on synced `ss_n`=0, go to SHIFT, set bit_count=0, and load the miso shift register with the status word.
- SHIFT:
  - On `sclk` rise: shift_reg <= {shift_reg[DATA_WIDTH-2:0], mosi}; bit_count++.
  - On the rise where bit_count==DATA_WIDTH-1: the word is complete. Push it next cycle, set bit_count=0, reload the status word for the next word. Multiple words per frame are allowed.
  - On `sclk` fall: `miso` <= next status bit.
  - Synced `ss_n`=1: go to IDLE. If bit_count≠0, set `frame_error` and discard the partial word.
  - A rise and a deselect in the same cycle: the rise is processed first.

Status word (MSB first):
- bit31 = `overflow`, bit30 = `frame_error`, bits29:27 = 0, bits26:24 = `fifo_count` zero-extended/truncated to 3 bits, bits23:0 = 0.
- It is captured at word start and drives `miso` from the first `sclk` fall.
- Before that first fall, `miso` presents bit31.
- `miso`=0 in WAIT_IDLE/IDLE.

FIFO:
- Push when a complete word arrives and `fifo_count`<FIFO_DEPTH.
- If full, the word is dropped and `overflow` is set.
- A push and pop in the same cycle when full: the pop frees the slot, so the push is accepted, no overflow is flagged, and the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Delivery:
- Pop when `fifo_count`>0, `hold_n`=1 and `latch_data`=0.
- On a pop, `cmd_data` <= head and `latch_data` <= 1 for exactly one cycle. Strobes are therefore spaced ≥2 cycles apart.
- `cmd_data` holds its value between strobes.
- Latency, empty FIFO with `hold_n`=1: push cycle N → `latch_data` high at N+1.
- `hold_n`=0 freezes delivery only; reception continues.

Errors:
- `clear_errors`=1 clears both sticky flags next edge.
- A new error event in the same cycle wins, and the flag stays set.

Test Plan:
1. Reset, `ss_n` high, then one frame shifting 0xA5C3_0F01 → exactly one `latch_data` pulse, `cmd_data`=0xA5C3_0F01, `fifo_count` returns to 0, no errors.
2. `hold_n`=0; one frame carrying 5 words 0x1..0x5 → `fifo_count`=4, `overflow`=1, word 0x5 dropped. Then `hold_n`=1 → strobes deliver 0x1,0x2,0x3,0x4 with ≥1 idle cycle between them.
3. Frame aborted after 12 bits, then a full word 0xDEAD_BEEF → `frame_error`=1, only 0xDEAD_BEEF delivered. `clear_errors` pulse → `frame_error`=0.
4. With `overflow`=1 and 3 words buffered, start a new word → first 8 `miso` bits = 1,0,0,0,0,0,1,1; remaining 24 bits = 0.
5. FIFO full with `hold_n` rising so a pop coincides with the push of the 5th word → `overflow` stays 0, `fifo_count` stays 4, all 5 words eventually delivered in order.
6. `reset_n` pulsed low after 20 bits of a word while `ss_n` stays low, then 32 more bits → nothing delivered until `ss_n` goes high. The next full frame 0x0000_0042 is delivered correctly.

Source files
------------

// File: rtl/spi_cmd_receiver.sv
// SPI (mode 0, MSB first) command receiver: synchronizes the pins, assembles
// DATA_WIDTH-bit words, buffers them in a small FIFO and delivers each one with
// a single-cycle latch_data strobe. A status word is shifted out on miso.
module spi_cmd_receiver #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned FIFO_ADDR_WIDTH = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       sclk,
  input  logic                       mosi,
  input  logic                       ss_n,
  output logic                       miso,
  input  logic                       hold_n,
  input  logic                       clear_errors,
  output logic [DATA_WIDTH-1:0]      cmd_data,
  output logic                       latch_data,
  output logic [FIFO_ADDR_WIDTH:0]   fifo_count,
  output logic                       overflow,
  output logic                       frame_error
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam int unsigned CW    = FIFO_ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]    FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT
  } state_e;

  state_e                     state_q;
  logic [2:0]                 sclk_sync_q;
  logic [1:0]                 mosi_sync_q;
  logic [1:0]                 ss_sync_q;
  logic [1:0]                 sync_warm_q;
  logic [CNT_W-1:0]           bit_count_q;
  logic [DATA_WIDTH-1:0]      shift_q;
  logic [DATA_WIDTH-1:0]      miso_sr_q;
  logic                       miso_q;
  logic                       word_valid_q;

  logic [DATA_WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q;
  logic [CW-1:0]              count_q;
  logic [CW-1:0]              count_d;
  logic [DATA_WIDTH-1:0]      cmd_q;
  logic                       latch_q;
  logic                       overflow_q;
  logic                       overflow_d;
  logic                       frame_error_q;
  logic                       frame_error_d;

  logic                       rise_c;
  logic                       fall_c;
  logic                       mosi_s;
  logic                       ss_s;
  logic                       word_done_c;
  logic                       frame_abort_c;
  logic                       full_c;
  logic                       pop_c;
  logic                       push_c;
  logic                       overflow_evt_c;
  logic [DATA_WIDTH-1:0]      status_c;

  assign rise_c = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign fall_c = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign mosi_s = mosi_sync_q[1];
  assign ss_s   = ss_sync_q[1];

  // A rise completing the word takes precedence over a same-cycle deselect.
  assign word_done_c   = (state_q == SHIFT) && rise_c && (bit_count_q == LAST_BIT);
  assign frame_abort_c = (state_q == SHIFT) && ss_s && !word_done_c &&
                         (rise_c || (bit_count_q != '0));

  assign full_c         = (count_q == FULL_COUNT);
  assign pop_c          = (count_q != '0) && hold_n && !latch_q;
  assign push_c         = word_valid_q && (!full_c || pop_c);
  assign overflow_evt_c = word_valid_q && full_c && !pop_c;

  // Status word shifted out on miso: flags, zeros, 3-bit fill level, zeros.
  always_comb begin
    status_c                   = '0;
    status_c[DATA_WIDTH-1]     = overflow_q;
    status_c[DATA_WIDTH-2]     = frame_error_q;
    status_c[DATA_WIDTH-6 -: 3] = 3'(count_q);
  end

  // Two-flop pin synchronizers; third sclk flop for edge detection.
  // sync_warm_q marks when the synchronizers hold real pin samples again.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sclk_sync_q <= 3'b000;
      mosi_sync_q <= 2'b00;
      ss_sync_q   <= 2'b11;
      sync_warm_q <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      ss_sync_q   <= {ss_sync_q[0], ss_n};
      sync_warm_q <= {sync_warm_q[0], 1'b1};
    end
  end

  // Frame state machine: bit assembly, word completion and miso shifting.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= WAIT_IDLE;
      bit_count_q  <= '0;
      shift_q      <= '0;
      miso_sr_q    <= '0;
      miso_q       <= 1'b0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      case (state_q)
        WAIT_IDLE: begin
          miso_q <= 1'b0;
          if (sync_warm_q[1] && ss_s) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          miso_q <= 1'b0;
          if (!ss_s) begin
            state_q     <= SHIFT;
            bit_count_q <= '0;
            miso_sr_q   <= status_c;
            miso_q      <= status_c[DATA_WIDTH-1];
          end
        end
        SHIFT: begin
          if (rise_c) begin
            shift_q <= {shift_q[DATA_WIDTH-2:0], mosi_s};
            if (word_done_c) begin
              word_valid_q <= 1'b1;
              bit_count_q  <= '0;
              miso_sr_q    <= status_c;
              miso_q       <= status_c[DATA_WIDTH-1];
            end else begin
              bit_count_q <= bit_count_q + CNT_W'(1);
            end
          end else if (fall_c && (bit_count_q != '0)) begin
            // Only advance once the current word has seen a rise, so the
            // trailing fall of the previous word leaves the new MSB in place.
            miso_q    <= miso_sr_q[DATA_WIDTH-2];
            miso_sr_q <= {miso_sr_q[DATA_WIDTH-2:0], 1'b0};
          end
          if (ss_s) begin
            state_q     <= IDLE;
            bit_count_q <= '0;
            miso_q      <= 1'b0;
          end
        end
        default: state_q <= WAIT_IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clock) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  // Next fill level and sticky flags; a new error beats a clear.
  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    overflow_d    = overflow_q;
    frame_error_d = frame_error_q;
    if (clear_errors) begin
      overflow_d    = 1'b0;
      frame_error_d = 1'b0;
    end
    if (overflow_evt_c) begin
      overflow_d = 1'b1;
    end
    if (frame_abort_c) begin
      frame_error_d = 1'b1;
    end
  end

  // FIFO pointers, delivery strobe and error flag registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cmd_q         <= '0;
      latch_q       <= 1'b0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      latch_q       <= pop_c;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      frame_error_q <= frame_error_d;
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + FIFO_ADDR_WIDTH'(1);
      end
      if (pop_c) begin
        cmd_q    <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + FIFO_ADDR_WIDTH'(1);
      end
    end
  end

  assign miso        = miso_q;
  assign cmd_data    = cmd_q;
  assign latch_data  = latch_q;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_cmd_receiver.sv
// Self-checking bench for spi_cmd_receiver: table vectors, randomized frames
// against a queue-based delivery model, and hand-written timing corner cases.
module tb_spi_cmd_receiver;

  localparam int HALF = 6;

  logic        clock = 1'b0;
  logic        reset_n, sclk, mosi, ss_n, miso, hold_n, clear_errors;
  logic [31:0] cmd_data;
  logic        latch_data;
  logic [2:0]  fifo_count;
  logic        overflow, frame_error;

  int checks = 0;
  int errors = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic        prev_latch = 1'b0;

  typedef struct {
    logic        hold_n;
    int          pre_abort;
    int          nwords;
    logic [31:0] base;
    logic [31:0] stride;
    int          exp_cnt;
    logic        exp_ovf;
    logic        exp_ferr;
  } vec_t;

  spi_cmd_receiver #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .FIFO_ADDR_WIDTH(2)) dut (
    .clock(clock), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .hold_n(hold_n), .clear_errors(clear_errors),
    .cmd_data(cmd_data), .latch_data(latch_data), .fifo_count(fifo_count),
    .overflow(overflow), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Collect delivered words; strobes must never be back to back.
  always @(negedge clock) begin
    if (latch_data === 1'b1) begin
      got_q.push_back(cmd_data);
      check("strobe_spacing", 32'(prev_latch), 32'd0);
    end
    prev_latch = latch_data;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One SPI bit; miso is sampled just before the rise, as a master would.
  task automatic spi_bit(input logic b, input logic release_hold, output logic sampled);
    mosi = b;
    tick(HALF);
    sampled = miso;
    sclk = 1'b1;
    if (release_hold) begin
      // hold_n rises so the first pop lands on the same edge as the push.
      tick(3);
      hold_n = 1'b1;
      tick(1);
      check("coinc_count", 32'(fifo_count), 32'd4);
      check("coinc_overflow", 32'(overflow), 32'd0);
      check("coinc_latch", 32'(latch_data), 32'd1);
      tick(HALF - 4);
    end else begin
      tick(HALF);
    end
    sclk = 1'b0;
  endtask

  task automatic spi_word(input logic [31:0] w, input logic release_last, output logic [31:0] m);
    logic s;
    for (int i = 31; i >= 0; i--) begin
      spi_bit(w[i], release_last && (i == 0), s);
      m[i] = s;
    end
  endtask

  task automatic spi_rand_bits(input int n);
    logic s;
    for (int i = 0; i < n; i++) spi_bit(1'($urandom_range(0, 1)), 1'b0, s);
  endtask

  task automatic spi_select();
    ss_n = 1'b0;
    tick(8);
  endtask

  task automatic spi_deselect();
    ss_n = 1'b1;
    tick(8);
  endtask

  task automatic clear_err();
    clear_errors = 1'b1;
    tick(1);
    clear_errors = 1'b0;
    tick(1);
  endtask

  // Release hold, wait (bounded) for the expected deliveries, compare in order.
  task automatic drain_and_compare(input string tag);
    hold_n = 1'b1;
    for (int i = 0; i < 400 && got_q.size() < exp_q.size(); i++) tick(1);
    tick(10);
    check({tag, "_ndeliv"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check({tag, "_word"}, got_q[i], exp_q[i]);
    end
    check({tag, "_count_empty"}, 32'(fifo_count), 32'd0);
    got_q.delete();
    exp_q.delete();
  endtask

  // Model: with hold released every word drains; with hold asserted the
  // FIFO keeps the first four words of the burst and drops the rest.
  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] w, m;
    clear_err();
    check({tag, "_clr_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_clr_ferr"}, 32'(frame_error), 32'd0);
    hold_n = v.hold_n;
    if (v.pre_abort > 0) begin
      spi_select();
      spi_rand_bits(v.pre_abort);
      spi_deselect();
    end
    spi_select();
    for (int i = 0; i < v.nwords; i++) begin
      w = v.base + 32'(i) * v.stride;
      spi_word(w, 1'b0, m);
      if (v.hold_n || i < 4) exp_q.push_back(w);
    end
    spi_deselect();
    tick(4);
    check({tag, "_count"}, 32'(fifo_count), 32'(v.exp_cnt));
    check({tag, "_overflow"}, 32'(overflow), 32'(v.exp_ovf));
    check({tag, "_frame_error"}, 32'(frame_error), 32'(v.exp_ferr));
    drain_and_compare(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vec_t rv;
    logic [31:0] m;

    vecs[0] = '{hold_n:1'b1, pre_abort:0,  nwords:1, base:32'hA5C3_0F01, stride:32'h0,
                exp_cnt:0, exp_ovf:1'b0, exp_ferr:1'b0};
    vecs[1] = '{hold_n:1'b0, pre_abort:0,  nwords:5, base:32'h1, stride:32'h1,
                exp_cnt:4, exp_ovf:1'b1, exp_ferr:1'b0};
    vecs[2] = '{hold_n:1'b1, pre_abort:12, nwords:1, base:32'hDEAD_BEEF, stride:32'h0,
                exp_cnt:0, exp_ovf:1'b0, exp_ferr:1'b1};
    vecs[3] = '{hold_n:1'b0, pre_abort:0,  nwords:3, base:32'h1111_1111, stride:32'h2222_2222,
                exp_cnt:3, exp_ovf:1'b0, exp_ferr:1'b0};
    vecs[4] = '{hold_n:1'b0, pre_abort:31, nwords:2, base:32'hFFFF_0000, stride:32'h0001_0001,
                exp_cnt:2, exp_ovf:1'b0, exp_ferr:1'b1};

    reset_n = 1'b0; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
    hold_n = 1'b1; clear_errors = 1'b0;
    tick(4);
    check("rst_cmd_data", cmd_data, 32'd0);
    check("rst_latch", 32'(latch_data), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    reset_n = 1'b1;
    tick(6);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Status word on miso with overflow set and three words buffered.
    clear_err();
    hold_n = 1'b0;
    spi_select();
    for (int i = 0; i < 5; i++) begin
      spi_word(32'h5000_0000 + 32'(i), 1'b0, m);
      if (i < 4) exp_q.push_back(32'h5000_0000 + 32'(i));
    end
    spi_deselect();
    hold_n = 1'b1;
    tick(1);
    hold_n = 1'b0;
    tick(3);
    check("st_count3", 32'(fifo_count), 32'd3);
    check("st_miso_idle", 32'(miso), 32'd0);
    spi_select();
    spi_word(32'h0BAD_CAFE, 1'b0, m);
    exp_q.push_back(32'h0BAD_CAFE);
    check("st_miso_word", m, 32'h8300_0000);
    spi_deselect();
    check("st_miso_after", 32'(miso), 32'd0);
    drain_and_compare("status");

    // Pop coinciding with the push into a full FIFO.
    clear_err();
    hold_n = 1'b0;
    spi_select();
    for (int i = 0; i < 4; i++) begin
      spi_word(32'hC0DE_0000 + 32'(i), 1'b0, m);
      exp_q.push_back(32'hC0DE_0000 + 32'(i));
    end
    spi_word(32'hC0DE_0004, 1'b1, m);
    exp_q.push_back(32'hC0DE_0004);
    spi_deselect();
    check("coinc_overflow_end", 32'(overflow), 32'd0);
    drain_and_compare("coinc");

    // Reset mid-frame with buffered words; wait for deselect before resync.
    clear_err();
    hold_n = 1'b0;
    spi_select();
    spi_word(32'h7777_0001, 1'b0, m);
    spi_word(32'h7777_0002, 1'b0, m);
    spi_rand_bits(20);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    hold_n = 1'b1;
    check("midrst_count", 32'(fifo_count), 32'd0);
    spi_rand_bits(32);
    tick(10);
    check("midrst_ndeliv", 32'(got_q.size()), 32'd0);
    check("midrst_count_after", 32'(fifo_count), 32'd0);
    check("midrst_ferr", 32'(frame_error), 32'd0);
    check("midrst_cmd", cmd_data, 32'd0);
    spi_deselect();
    spi_select();
    spi_word(32'h0000_0042, 1'b0, m);
    exp_q.push_back(32'h0000_0042);
    spi_deselect();
    drain_and_compare("midrst");

    // Randomized frames against the delivery model.
    for (int it = 0; it < 10; it++) begin
      rv.hold_n    = 1'($urandom_range(0, 1));
      rv.pre_abort = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 31)) : 0;
      rv.nwords    = rv.hold_n ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 6));
      rv.base      = $urandom;
      rv.stride    = $urandom;
      rv.exp_cnt   = rv.hold_n ? 0 : ((rv.nwords > 4) ? 4 : rv.nwords);
      rv.exp_ovf   = !rv.hold_n && (rv.nwords > 4);
      rv.exp_ferr  = (rv.pre_abort != 0);
      run_vec(rv, $sformatf("rand%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
